prbs_checker: RTL and testbench
===============================

# prbs_checker

Receive-side counterpart to the `lfsr` generator. Consumes a serial PRBS bit stream produced by an 8-bit Fibonacci LFSR, self-synchronizes its local LFSR state to the stream, declares lock, then counts bit errors against its own prediction. Drops lock on an excessive error rate and re-hunts. Sits at the link sink, after bit recovery.

## Interface

Parameters:
- `LOCK_COUNT`, default 16: consecutive correct predictions required to declare lock.
- `ERR_WINDOW`, default 64: length of the error-rate window, in valid bits.
- `ERR_LIMIT`, default 4: errors within one window that force loss of lock.
- `CNT_WIDTH`, default 16: width of `errCount`.

Ports:
- `clock`  in  1  sole clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `tapIn`  in  8  desired tap mask, same meaning as the generator's taps.
- `tapEn`  in  1  tap write enable.
- `bitIn`  in  1  received PRBS bit.
- `bitValid`  in  1  `bitIn` is valid this cycle.
- `clear`  in  1  synchronous clear of `errCount`.
- `locked`  out  1  checker is in LOCKED state.
- `errPulse`  out  1  one-cycle pulse per detected error while locked.
- `errCount`  out  CNT_WIDTH  saturating count of errors detected while locked.

## Operation

- The local state is `state[7:0]`. Step rule matches the generator: `pred = ^(state & taps)`; next state is `{state[6:0], b}`, where `b` is the bit shifted in.
- Taps register resets to 8'hB8 (x^8+x^6+x^5+x^4+1). A `tapEn` write loads `tapIn` and forces state SEED.
- FSM states:
  - SEED: each valid bit is shifted into `state` (`b = bitIn`), with `fill` counting 0..7. After the 8th bit, go to HUNT if the new state is nonzero. If the new state is all-zero, restart the fill.
  - HUNT: each valid bit is compared with `pred`, and `b = bitIn`. On a match, `run++`; on a mismatch, `run = 0`. Go to LOCKED when `run` reaches LOCK_COUNT.
  - LOCKED (flywheel): `b = pred`, so received errors do not corrupt the state. A mismatch pulses `errPulse`, increments `errCount` (saturating at all-ones) and increments `winErr`. `winBits` counts valid bits 0..ERR_WINDOW-1; `winErr` resets at wrap. When `winErr` reaches ERR_LIMIT, go to SEED.
- Cycles with `bitValid = 0` change nothing except `tapEn` and `clear`.
- Errors are counted only in LOCKED. HUNT mismatches are never counted.
- `clear` zeroes `errCount`. If `clear` and an error occur in the same cycle, clear wins (`errCount = 0`), and `errPulse` still fires.
- Priority: reset > `tapEn` > bit processing. A `tapEn` in the same cycle as a valid bit discards that bit.

## Timing

- Reset values:
  - `locked = 0`, `errPulse = 0`, `errCount = 0`.
  - taps = 8'hB8, state = 0, FSM = SEED.
  - `fill`, `run`, `winBits`, `winErr` all 0.
- All outputs are registered.
- `errPulse` asserts on the cycle after the offending valid bit's edge, for exactly 1 cycle.
- `locked` rises on the edge that consumes the LOCK_COUNT-th consecutive matching bit. Minimum: 8 + LOCK_COUNT valid bits after SEED entry.
- `locked` falls on the edge that consumes the ERR_LIMIT-th error in a window.
- `errCount` updates on the same edge as `errPulse` rises.
- Mid-operation reset returns to the reset values immediately (asynchronously).

## Structure

- Package `lfsr_pkg` holds:
  - `DEFAULT_TAPS = 8'hB8`
  - enum `chk_state_t {SEED, HUNT, LOCKED}`
  - the step function `lfsr_pred(state, taps)`, which is shared with the generator side.
- The existing `lfsr` module is the natural sub-module for the prediction and tap register: `in = state`, with `tapIn`/`tapEn` passed through. Its `out[0]` is `pred`.
- The FSM, counters and error logic live in `prbs_checker`.

## Test plan

- Clean stream: generator with taps B8 and seed 8'h01 drives 24 valid bits. Required: `locked` rises after bit 24; `errCount` stays 0 over the next 1000 bits.
- Single error: after lock, invert one bit. Required: `errPulse` high for 1 cycle, `errCount = 1`, `locked` stays 1, and the next 100 bits produce no further errors (flywheel).
- Loss of lock: after lock, invert 4 bits within 64. Required: `locked` falls on the 4th error and relock occurs after 24 clean bits. A second run with only 3 errors in a window must keep lock.
- Taps change: with the checker locked, write `tapIn = 8'hE1` via `tapEn`. Required: `locked = 0` next cycle. A stream from a generator with taps E1 relocks after 24 bits.
- Zero and gaps: 8 zero bits must keep the checker in SEED. Random `bitValid` gaps on a clean stream must still lock after 24 valid bits.
- Clear and saturation: with `CNT_WIDTH = 4`, inject 20 spaced errors. Required: `errCount` holds at 15. `clear` together with an error gives `errCount = 0` and `errPulse = 1`.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the PRBS generator and checker.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package lfsr_pkg;

    // x^8 + x^6 + x^5 + x^4 + 1
    localparam logic [7:0] DEFAULT_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        SEED,
        HUNT,
        LOCKED
    } chk_state_t;

    // Next bit predicted by a Fibonacci LFSR: parity of the tapped state bits.
    function automatic logic lfsr_pred(input logic [7:0] state, input logic [7:0] taps);
        return ^(state & taps);
    endfunction

endpackage

// File: rtl/lfsr.sv
// Tap register plus one-step Fibonacci LFSR advance (predicted bit enters at bit 0).
// Latency: out is combinational from in; a tap write takes effect one cycle after tapEn.
// Backpressure: none; the caller decides when out is consumed.
module lfsr
    import lfsr_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] tapIn,
    input  logic       tapEn,
    input  logic [7:0] in,
    output logic [7:0] out
);

    logic [7:0] taps_q;

    // Tap mask register, loaded whenever tapEn is asserted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            taps_q <= DEFAULT_TAPS;
        end else if (tapEn) begin
            taps_q <= tapIn;
        end
    end

    // One LFSR step: shift left, the predicted bit becomes the newest bit.
    always_comb begin
        out = {in[6:0], lfsr_pred(in, taps_q)};
    end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: seed from the stream, hunt for lock, then count errors.
// Latency: all outputs registered; errPulse/errCount/locked change on the edge consuming the bit.
// Backpressure: none; bitValid=0 cycles are simply skipped (only tapEn and clear act).
module prbs_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_COUNT = 16,
    parameter int ERR_WINDOW = 64,
    parameter int ERR_LIMIT  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [7:0]           tapIn,
    input  logic                 tapEn,
    input  logic                 bitIn,
    input  logic                 bitValid,
    input  logic                 clear,
    output logic                 locked,
    output logic                 errPulse,
    output logic [CNT_WIDTH-1:0] errCount
);

    localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
    localparam int WIN_W  = (ERR_WINDOW > 1) ? $clog2(ERR_WINDOW) : 1;
    localparam int WERR_W = $clog2(ERR_LIMIT + 1);

    localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(LOCK_COUNT - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(ERR_WINDOW - 1);
    localparam logic [WERR_W-1:0] ERR_MAX  = WERR_W'(ERR_LIMIT);

    chk_state_t           fsm_q;
    logic [7:0]           state_q;
    logic [2:0]           fill_q;
    logic [RUN_W-1:0]     run_q;
    logic [WIN_W-1:0]     win_bits_q;
    logic [WERR_W-1:0]    win_err_q;
    logic                 locked_q;
    logic                 err_pulse_q;
    logic [CNT_WIDTH-1:0] err_cnt_q;
    logic [CNT_WIDTH-1:0] err_cnt_d;

    logic [7:0]        step_out;
    logic              pred;
    logic              mismatch;
    logic [7:0]        shift_rx;
    logic [WERR_W-1:0] win_err_inc;
    logic              err_hit;

    lfsr u_lfsr (
        .clock   (clock),
        .reset_n (reset_n),
        .tapIn   (tapIn),
        .tapEn   (tapEn),
        .in      (state_q),
        .out     (step_out)
    );

    // Prediction compare, received-bit shift and the error counter's next value.
    always_comb begin
        pred        = step_out[0];
        mismatch    = bitIn ^ pred;
        shift_rx    = {state_q[6:0], bitIn};
        win_err_inc = win_err_q + WERR_W'(mismatch);
        err_hit     = bitValid && !tapEn && (fsm_q == LOCKED) && mismatch;
        err_cnt_d   = err_cnt_q;
        if (clear) begin
            err_cnt_d = '0;
        end else if (err_hit && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
        end
    end

    // Checker FSM: SEED fills the state, HUNT verifies it, LOCKED flywheels on prediction.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q       <= SEED;
            state_q     <= 8'h00;
            fill_q      <= 3'd0;
            run_q       <= '0;
            win_bits_q  <= '0;
            win_err_q   <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            err_pulse_q <= 1'b0;
            err_cnt_q   <= err_cnt_d;
            if (tapEn) begin
                // New polynomial invalidates the current state; any same-cycle bit is dropped.
                fsm_q      <= SEED;
                fill_q     <= 3'd0;
                run_q      <= '0;
                win_bits_q <= '0;
                win_err_q  <= '0;
                locked_q   <= 1'b0;
            end else if (bitValid) begin
                unique case (fsm_q)
                    SEED: begin
                        // fill wraps 7->0 by itself, so an all-zero fill just starts over.
                        state_q <= shift_rx;
                        fill_q  <= fill_q + 3'd1;
                        if ((fill_q == 3'd7) && (shift_rx != 8'h00)) begin
                            fsm_q <= HUNT;
                            run_q <= '0;
                        end
                    end
                    HUNT: begin
                        state_q <= shift_rx;
                        if (mismatch) begin
                            run_q <= '0;
                        end else if (run_q == RUN_LAST) begin
                            fsm_q      <= LOCKED;
                            locked_q   <= 1'b1;
                            run_q      <= '0;
                            win_bits_q <= '0;
                            win_err_q  <= '0;
                        end else begin
                            run_q <= run_q + RUN_W'(1);
                        end
                    end
                    LOCKED: begin
                        // Flywheel: advance on our own prediction so line errors never enter state.
                        state_q <= step_out;
                        if (mismatch) begin
                            err_pulse_q <= 1'b1;
                        end
                        if (win_err_inc == ERR_MAX) begin
                            fsm_q    <= SEED;
                            locked_q <= 1'b0;
                            fill_q   <= 3'd0;
                        end else if (win_bits_q == WIN_LAST) begin
                            win_bits_q <= '0;
                            win_err_q  <= '0;
                        end else begin
                            win_bits_q <= win_bits_q + WIN_W'(1);
                            win_err_q  <= win_err_inc;
                        end
                    end
                    default: begin
                        fsm_q <= SEED;
                    end
                endcase
            end
        end
    end

    assign locked   = locked_q;
    assign errPulse = err_pulse_q;
    assign errCount = err_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: directed scenarios, a scenario table, and random traffic vs a reference model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_prbs_checker;

    localparam int CW    = 4;
    localparam int LOCK  = 16;
    localparam int WIN   = 64;
    localparam int LIMIT = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clock    = 1'b0;
    logic          reset_n  = 1'b0;
    logic [7:0]    tapIn    = 8'h00;
    logic          tapEn    = 1'b0;
    logic          bitIn    = 1'b0;
    logic          bitValid = 1'b0;
    logic          clear    = 1'b0;
    logic          locked;
    logic          errPulse;
    logic [CW-1:0] errCount;

    prbs_checker #(
        .LOCK_COUNT (LOCK),
        .ERR_WINDOW (WIN),
        .ERR_LIMIT  (LIMIT),
        .CNT_WIDTH  (CW)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .tapIn    (tapIn),
        .tapEn    (tapEn),
        .bitIn    (bitIn),
        .bitValid (bitValid),
        .clear    (clear),
        .locked   (locked),
        .errPulse (errPulse),
        .errCount (errCount)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- stimulus generator (transmit-side LFSR) ----------------
    logic [7:0] g_hist;
    logic [7:0] g_taps;

    task automatic gen(output logic b);
        logic nb;
        nb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (g_taps[i]) nb = nb ^ g_hist[i];
        end
        g_hist = {g_hist[6:0], nb};
        b = nb;
    endtask

    // ---------------- reference model ----------------
    // h[i] is the bit received i+1 valid bits ago; mode 0=seed 1=hunt 2=locked.
    logic       h [8];
    logic [7:0] m_taps;
    int         m_mode, m_since, m_run, m_lockbits, m_win, m_werr, m_cnt;
    logic       m_locked, m_pulse;

    function automatic logic m_pred();
        logic p;
        p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (m_taps[i] && h[i]) p = ~p;
        end
        return p;
    endfunction

    task automatic push(input logic x);
        for (int i = 7; i > 0; i--) h[i] = h[i-1];
        h[0] = x;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) h[i] = 1'b0;
        m_taps = 8'hB8;
        m_mode = 0; m_since = 0; m_run = 0; m_lockbits = 0; m_win = 0; m_werr = 0; m_cnt = 0;
        m_locked = 1'b0; m_pulse = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic b, input logic te,
                              input logic [7:0] ti, input logic clr);
        logic p;
        logic any;
        m_pulse = 1'b0;
        if (te) begin
            m_taps = ti; m_mode = 0; m_since = 0; m_run = 0; m_locked = 1'b0;
        end else if (v) begin
            p = m_pred();
            if (m_mode == 0) begin
                push(b);
                m_since++;
                any = 1'b0;
                for (int i = 0; i < 8; i++) any = any | h[i];
                if ((m_since % 8 == 0) && any) begin
                    m_mode = 1; m_run = 0;
                end
            end else if (m_mode == 1) begin
                push(b);
                if (b == p) begin
                    m_run++;
                    if (m_run == LOCK) begin
                        m_mode = 2; m_locked = 1'b1; m_lockbits = 0; m_win = 0; m_werr = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end else begin
                push(p);
                if (m_lockbits / WIN != m_win) begin
                    m_win = m_lockbits / WIN; m_werr = 0;
                end
                m_lockbits++;
                if (b != p) begin
                    m_pulse = 1'b1;
                    if (m_cnt < CMAX) m_cnt++;
                    m_werr++;
                    if (m_werr == LIMIT) begin
                        m_mode = 0; m_since = 0; m_locked = 1'b0;
                    end
                end
            end
        end
        if (clr) m_cnt = 0;
    endtask

    // ---------------- drive helpers ----------------
    task automatic cyc(input logic v, input logic b, input logic te,
                       input logic [7:0] ti, input logic clr);
        logic [CW-1:0] mc;
        bitValid = v; bitIn = b; tapEn = te; tapIn = ti; clear = clr;
        @(posedge clock);
        model_step(v, b, te, ti, clr);
        #1;
        mc = m_cnt[CW-1:0];
        check("cycle_vs_model", 32'({locked, errPulse, errCount}), 32'({m_locked, m_pulse, mc}));
        bitValid = 1'b0; tapEn = 1'b0; clear = 1'b0;
    endtask

    task automatic clean(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            gen(b);
            cyc(1'b1, b, 1'b0, 8'h00, 1'b0);
        end
    endtask

    task automatic bad(input logic clr);
        logic b;
        gen(b);
        cyc(1'b1, ~b, 1'b0, 8'h00, clr);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #2;
        check("reset_outputs", 32'({locked, errPulse, errCount}), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        g_hist = 8'h01;
        g_taps = 8'hB8;
    endtask

    typedef struct {
        int   errs;
        int   gap;
        logic exp_mid;
        logic exp_fin;
        int   exp_cnt;
    } scen_t;

    scen_t tbl [6];

    initial begin
        logic       b, v, te, clr;
        logic [7:0] nt;
        int         n;

        // errors injected 5 bits after lock, 'gap' clean bits apart; then 23 and 24 clean bits
        tbl[0] = '{1,  0, 1'b1, 1'b1, 1};
        tbl[1] = '{3,  9, 1'b1, 1'b1, 3};
        tbl[2] = '{4,  9, 1'b0, 1'b1, 4};
        tbl[3] = '{4, 18, 1'b0, 1'b1, 4};  // offsets 5,24,43,62: one window
        tbl[4] = '{4, 19, 1'b1, 1'b1, 4};  // offsets 5,25,45,65: 4th lands in next window
        tbl[5] = '{4,  0, 1'b0, 1'b1, 4};

        @(posedge clock);
        #1;
        reset_n = 1'b1;
        do_reset();

        // clean stream: lock exactly on the 24th valid bit, no errors afterwards
        clean(23);
        check("no_lock_at_23", 32'(locked), 0);
        clean(1);
        check("lock_at_24", 32'(locked), 1);
        clean(1000);
        check("clean_errcount", 32'(errCount), 0);
        check("clean_locked", 32'(locked), 1);

        // single error while locked
        bad(1'b0);
        check("single_pulse", 32'(errPulse), 1);
        check("single_cnt", 32'(errCount), 1);
        check("single_locked", 32'(locked), 1);
        clean(1);
        check("pulse_one_cycle", 32'(errPulse), 0);
        clean(99);
        check("flywheel_cnt", 32'(errCount), 1);
        check("pre_reset_locked", 32'(locked), 1);

        // error-window scenarios
        for (int s = 0; s < 6; s++) begin
            do_reset();
            clean(29);
            for (int k = 0; k < tbl[s].errs; k++) begin
                bad(1'b0);
                if (k < tbl[s].errs - 1) clean(tbl[s].gap);
            end
            check($sformatf("scen%0d_cnt", s), 32'(errCount), 32'(tbl[s].exp_cnt));
            clean(23);
            check($sformatf("scen%0d_locked_mid", s), 32'(locked), 32'(tbl[s].exp_mid));
            clean(1);
            check($sformatf("scen%0d_locked_fin", s), 32'(locked), 32'(tbl[s].exp_fin));
        end

        // tap change while locked; same-cycle valid bit is discarded
        do_reset();
        clean(24);
        cyc(1'b1, 1'b0, 1'b1, 8'hE1, 1'b0);
        check("tap_unlock", 32'(locked), 0);
        g_taps = 8'hE1;
        clean(23);
        check("e1_no_lock_23", 32'(locked), 0);
        clean(1);
        check("e1_lock_24", 32'(locked), 1);

        // all-zero stream never leaves SEED
        do_reset();
        repeat (32) cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("zero_no_lock", 32'(locked), 0);

        // random bitValid gaps on a clean stream
        do_reset();
        n = 0;
        while (n < 24) begin
            if ($urandom_range(0, 2) == 0) begin
                cyc(1'b0, 1'($urandom), 1'b0, 8'h00, 1'b0);
            end else begin
                clean(1);
                n++;
                if (n == 23) check("gap_no_lock_23", 32'(locked), 0);
            end
        end
        check("gap_lock_24", 32'(locked), 1);

        // saturation at 15 with spaced errors, then clear racing an error
        do_reset();
        clean(24);
        repeat (20) begin
            bad(1'b0);
            clean(24);
        end
        check("sat_cnt", 32'(errCount), 15);
        check("sat_locked", 32'(locked), 1);
        bad(1'b1);
        check("clear_err_pulse", 32'(errPulse), 1);
        check("clear_err_cnt", 32'(errCount), 0);

        // randomized traffic against the model
        do_reset();
        repeat (3000) begin
            v   = ($urandom_range(0, 3) != 0);
            te  = ($urandom_range(0, 199) == 0);
            clr = ($urandom_range(0, 99) == 0);
            nt  = ($urandom_range(0, 1) == 0) ? 8'hB8 : 8'hE1;
            if (te) begin
                cyc(v, 1'($urandom), 1'b1, nt, clr);
                g_taps = nt;
            end else if (v) begin
                gen(b);
                if ($urandom_range(0, 29) == 0) b = ~b;
                cyc(1'b1, b, 1'b0, 8'h00, clr);
            end else begin
                cyc(1'b0, 1'($urandom), 1'b0, 8'h00, clr);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
